// File: rtl/leaf_port_bridge.sv
// leaf_port_bridge: tagged-stream demux/merge between leaf_interface and HLS kernel ports.
// Per-port first-word-fall-through FIFOs on both sides, round-robin merge on egress.

module leaf_port_bridge_fifo #(
  parameter int W  = 32,
  parameter int AW = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         wr_i,
  input  logic [W-1:0] din_i,
  input  logic         rd_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  logic [W-1:0]  mem_q [2**AW];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          do_wr, do_rd;

  // occupancy MSB is set only at exactly 2**AW words
  assign full_o  = cnt_q[AW];
  assign empty_o = (cnt_q == '0);
  assign do_wr   = wr_i && !full_o;
  assign do_rd   = rd_i && !empty_o;
  assign dout_o  = mem_q[rp_q];

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wp_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_wr) wp_q <= wp_q + 1'b1;
      if (do_rd) rp_q <= rp_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module leaf_port_bridge #(
  parameter int PAYLOAD_BITS    = 32,
  parameter int NUM_PORT_BITS   = 4,
  parameter int NUM_IN_PORTS    = 2,
  parameter int NUM_OUT_PORTS   = 2,
  parameter int FIFO_DEPTH_BITS = 3
) (
  input  logic                                  clk_user,
  input  logic                                  reset_n,
  input  logic [PAYLOAD_BITS-1:0]               s_din,
  input  logic [NUM_PORT_BITS-1:0]              s_port,
  input  logic                                  s_vld,
  output logic                                  s_ack,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  u_dout,
  output logic [NUM_IN_PORTS-1:0]               u_vld,
  input  logic [NUM_IN_PORTS-1:0]               u_ack,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] u_din,
  input  logic [NUM_OUT_PORTS-1:0]              u_din_vld,
  output logic [NUM_OUT_PORTS-1:0]              u_din_ack,
  output logic [PAYLOAD_BITS-1:0]               m_dout,
  output logic [NUM_PORT_BITS-1:0]              m_port,
  output logic                                  m_vld,
  input  logic                                  m_ack,
  output logic [7:0]                            bad_port_cnt
);
  localparam int RRW = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [NUM_PORT_BITS:0] NIN = (NUM_PORT_BITS+1)'(NUM_IN_PORTS);

  logic [NUM_IN_PORTS-1:0]  ihit, ifull, iempty, iwr, ird;
  logic [NUM_OUT_PORTS-1:0] efull, eempty, ewr, epop;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] ehead;
  logic s_bad;

  logic [PAYLOAD_BITS-1:0]  m_dout_q, m_dout_d;
  logic [NUM_PORT_BITS-1:0] m_port_q, m_port_d;
  logic                     m_vld_q, m_vld_d;
  logic [RRW-1:0]           rr_q, rr_d, win, idx;
  logic [7:0]               bad_q, bad_d;
  logic                     found, load;

  assign s_bad = ({1'b0, s_port} >= NIN);
  assign s_ack = reset_n && (s_bad || |(ihit & ~ifull));
  assign u_vld = reset_n ? ~iempty : '0;
  assign ird   = u_vld & u_ack;

  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
    assign ihit[i] = (s_port == NUM_PORT_BITS'(i));
    assign iwr[i]  = reset_n && s_vld && ihit[i] && !ifull[i];
    leaf_port_bridge_fifo #(
      .W  (PAYLOAD_BITS),
      .AW (FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk_i   (clk_user),
      .rst_ni  (reset_n),
      .wr_i    (iwr[i]),
      .din_i   (s_din),
      .rd_i    (ird[i]),
      .dout_o  (u_dout[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .full_o  (ifull[i]),
      .empty_o (iempty[i])
    );
  end

  assign u_din_ack = reset_n ? ~efull : '0;
  assign ewr       = u_din_vld & u_din_ack;

  for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_out
    leaf_port_bridge_fifo #(
      .W  (PAYLOAD_BITS),
      .AW (FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk_i   (clk_user),
      .rst_ni  (reset_n),
      .wr_i    (ewr[i]),
      .din_i   (u_din[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_i    (epop[i]),
      .dout_o  (ehead[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .full_o  (efull[i]),
      .empty_o (eempty[i])
    );
  end

  // first non-empty egress FIFO at or after rr_q, wrapping
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      idx = RRW'((int'(rr_q) + k) % NUM_OUT_PORTS);
      if (!found && !eempty[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign load = (!m_vld_q || m_ack) && found;

  always_comb begin
    m_dout_d = m_dout_q;
    m_port_d = m_port_q;
    m_vld_d  = m_vld_q;
    rr_d     = rr_q;
    epop     = '0;
    if (load) begin
      epop[win] = 1'b1;
      m_dout_d  = ehead[int'(win)*PAYLOAD_BITS +: PAYLOAD_BITS];
      m_port_d  = NUM_PORT_BITS'(win);
      m_vld_d   = 1'b1;
      rr_d      = RRW'((int'(win) + 1) % NUM_OUT_PORTS);
    end else if (m_ack) begin
      m_vld_d = 1'b0;
    end
  end

  always_comb begin
    bad_d = bad_q;
    if (s_vld && s_bad && bad_q != 8'hFF) bad_d = bad_q + 8'd1;
  end

  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      m_dout_q <= '0;
      m_port_q <= '0;
      m_vld_q  <= 1'b0;
      rr_q     <= '0;
      bad_q    <= '0;
    end else begin
      m_dout_q <= m_dout_d;
      m_port_q <= m_port_d;
      m_vld_q  <= m_vld_d;
      rr_q     <= rr_d;
      bad_q    <= bad_d;
    end
  end

  assign m_dout       = m_dout_q;
  assign m_port       = m_port_q;
  assign m_vld        = m_vld_q;
  assign bad_port_cnt = bad_q;
endmodule

// File: tb/tb_leaf_port_bridge.sv
// tb_leaf_port_bridge: random traffic against a queue-based model of the bridge.
// Inputs change on the falling edge; outputs are compared 1ns later.

module tb_leaf_port_bridge;
  localparam int PB = 32;
  localparam int NI = 2;
  localparam int NO = 2;

  logic clk_user = 1'b0;
  logic reset_n  = 1'b0;
  logic [PB-1:0]    s_din = '0;
  logic [3:0]       s_port = '0;
  logic             s_vld = 1'b0;
  logic             s_ack;
  logic [NI*PB-1:0] u_dout;
  logic [NI-1:0]    u_vld;
  logic [NI-1:0]    u_ack = '0;
  logic [NO*PB-1:0] u_din = '0;
  logic [NO-1:0]    u_din_vld = '0;
  logic [NO-1:0]    u_din_ack;
  logic [PB-1:0]    m_dout;
  logic [3:0]       m_port;
  logic             m_vld;
  logic             m_ack = 1'b0;
  logic [7:0]       bad_port_cnt;

  leaf_port_bridge #(
    .PAYLOAD_BITS    (PB),
    .NUM_PORT_BITS   (4),
    .NUM_IN_PORTS    (NI),
    .NUM_OUT_PORTS   (NO),
    .FIFO_DEPTH_BITS (3)
  ) dut (
    .clk_user     (clk_user),
    .reset_n      (reset_n),
    .s_din        (s_din),
    .s_port       (s_port),
    .s_vld        (s_vld),
    .s_ack        (s_ack),
    .u_dout       (u_dout),
    .u_vld        (u_vld),
    .u_ack        (u_ack),
    .u_din        (u_din),
    .u_din_vld    (u_din_vld),
    .u_din_ack    (u_din_ack),
    .m_dout       (m_dout),
    .m_port       (m_port),
    .m_vld        (m_vld),
    .m_ack        (m_ack),
    .bad_port_cnt (bad_port_cnt)
  );

  always #5 clk_user = ~clk_user;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference state
  logic [31:0] iq [NI][$];
  logic [31:0] eq [NO][$];
  bit          mv;
  logic [31:0] mdout;
  int          mport, rr, bcnt;
  bit          s_keep;
  bit [NO-1:0] ud_keep;

  int p_svld, p_bad, p_p0, p_uack0, p_uack1, p_udv, p_mack;

  function automatic bit rnd(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  task automatic cycle();
    bit sbad, exp_sack, sacc, ld;
    bit [NI-1:0] ipop;
    bit [NO-1:0] eacc;
    int sp, w;
    if (!s_keep) begin
      s_vld = rnd(p_svld);
      s_din = $urandom;
      if (rnd(p_bad)) s_port = 4'($urandom_range(15, NI));
      else s_port = rnd(p_p0) ? 4'd0 : 4'd1;
    end
    u_ack[0] = rnd(p_uack0);
    u_ack[1] = rnd(p_uack1);
    for (int i = 0; i < NO; i++) begin
      if (!ud_keep[i]) begin
        u_din_vld[i] = rnd(p_udv);
        u_din[i*PB +: PB] = $urandom;
      end
    end
    m_ack = rnd(p_mack);
    #1;
    sp = int'(s_port);
    sbad = (sp >= NI);
    exp_sack = sbad ? 1'b1 : (iq[sp].size() < 8);
    chk("s_ack", 32'(s_ack), 32'(exp_sack));
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u_vld%0d", i), 32'(u_vld[i]), 32'(iq[i].size() != 0));
      if (iq[i].size() != 0)
        chk($sformatf("u_dout%0d", i), u_dout[i*PB +: PB], iq[i][0]);
    end
    for (int i = 0; i < NO; i++)
      chk($sformatf("u_din_ack%0d", i), 32'(u_din_ack[i]),
          32'(eq[i].size() < 8));
    chk("m_vld", 32'(m_vld), 32'(mv));
    if (mv) begin
      chk("m_dout", m_dout, mdout);
      chk("m_port", 32'(m_port), 32'(mport));
    end
    chk("bad_port_cnt", 32'(bad_port_cnt), 32'(bcnt));

    // transfers decided on pre-edge state, then applied
    sacc = s_vld && exp_sack;
    for (int i = 0; i < NI; i++) ipop[i] = u_ack[i] && iq[i].size() != 0;
    for (int i = 0; i < NO; i++) eacc[i] = u_din_vld[i] && eq[i].size() < 8;
    ld = (!mv || m_ack) && (eq[0].size() != 0 || eq[1].size() != 0);
    w = -1;
    if (ld)
      for (int k = 0; k < NO; k++)
        if (w < 0 && eq[(rr + k) % NO].size() != 0) w = (rr + k) % NO;
    for (int i = 0; i < NI; i++) if (ipop[i]) void'(iq[i].pop_front());
    if (sacc) begin
      if (sbad) bcnt = (bcnt < 255) ? bcnt + 1 : 255;
      else iq[sp].push_back(s_din);
    end
    if (ld) begin
      mdout = eq[w].pop_front();
      mport = w;
      mv = 1'b1;
      rr = (w + 1) % NO;
    end else if (m_ack) begin
      mv = 1'b0;
    end
    for (int i = 0; i < NO; i++) begin
      if (eacc[i]) eq[i].push_back(u_din[i*PB +: PB]);
      ud_keep[i] = u_din_vld[i] && !eacc[i];
    end
    s_keep = s_vld && !sacc;
    @(negedge clk_user);
  endtask

  task automatic phase(input int n, input int svld, input int pbad,
                       input int p0, input int ua0, input int ua1,
                       input int udv, input int mack);
    p_svld = svld; p_bad = pbad; p_p0 = p0;
    p_uack0 = ua0; p_uack1 = ua1; p_udv = udv; p_mack = mack;
    repeat (n) cycle();
  endtask

  // s_vld held on a bad tag: s_ack must still be forced low
  task automatic do_reset();
    s_vld = 1'b1;
    s_port = 4'd5;
    u_din_vld = '1;
    reset_n = 1'b0;
    #1;
    chk("rst_m_vld", 32'(m_vld), 32'd0);
    chk("rst_u_vld", 32'(u_vld), 32'd0);
    chk("rst_s_ack", 32'(s_ack), 32'd0);
    chk("rst_u_din_ack", 32'(u_din_ack), 32'd0);
    chk("rst_bad_cnt", 32'(bad_port_cnt), 32'd0);
    chk("rst_m_port", 32'(m_port), 32'd0);
    chk("rst_m_dout", m_dout, 32'd0);
    for (int i = 0; i < NI; i++) iq[i].delete();
    for (int i = 0; i < NO; i++) eq[i].delete();
    mv = 1'b0; mdout = '0; mport = 0; rr = 0; bcnt = 0;
    s_keep = 1'b0; ud_keep = '0;
    s_vld = 1'b0;
    u_din_vld = '0;
    repeat (2) @(negedge clk_user);
    reset_n = 1'b1;
  endtask

  initial begin
    @(negedge clk_user);
    do_reset();
    phase(300, 70, 10, 50, 70, 70, 60, 70);
    phase(60, 90, 0, 85, 0, 80, 0, 100);
    phase(40, 60, 0, 50, 80, 80, 0, 100);
    phase(100, 0, 0, 50, 100, 100, 100, 100);
    phase(30, 0, 0, 50, 100, 100, 100, 0);
    phase(80, 0, 0, 50, 100, 100, 50, 100);
    phase(40, 80, 10, 50, 0, 0, 80, 0);
    do_reset();
    phase(200, 60, 10, 50, 70, 70, 60, 70);
    phase(350, 100, 100, 50, 50, 50, 0, 100);
    chk("bad_sat", 32'(bad_port_cnt), 32'd255);
    phase(200, 70, 20, 50, 60, 60, 70, 60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
